// File: rtl/prescaled_counter_if.sv
// Bus interface for prescaled_counter: groups the control, data and status
// signals. The slave modport is the counter side, the master modport is the
// side that drives the controls and observes the count.
interface prescaled_counter_if #(
  parameter int WIDTH          = 8,
  parameter int PRESCALE_WIDTH = 8
);
  logic                      enable_i;
  logic                      clear_i;
  logic                      load_i;
  logic [WIDTH-1:0]          load_value_i;
  logic                      up_i;
  logic                      saturate_i;
  logic [PRESCALE_WIDTH-1:0] divide_i;
  logic [WIDTH-1:0]          compare_i;
  logic [WIDTH-1:0]          count_o;
  logic [PRESCALE_WIDTH-1:0] prescale_o;
  logic                      tick_o;
  logic                      wrap_o;
  logic                      full_o;
  logic                      zero_o;
  logic                      match_o;

  modport slave (
    input  enable_i, clear_i, load_i, load_value_i, up_i, saturate_i,
           divide_i, compare_i,
    output count_o, prescale_o, tick_o, wrap_o, full_o, zero_o, match_o
  );

  modport master (
    output enable_i, clear_i, load_i, load_value_i, up_i, saturate_i,
           divide_i, compare_i,
    input  count_o, prescale_o, tick_o, wrap_o, full_o, zero_o, match_o
  );
endinterface

// File: rtl/prescaled_counter.sv
// prescaled_counter: WIDTH-bit up/down counter stepped by a runtime-programmable
// prescaler, with wrap or saturate at the limits, synchronous clear and load.
// Optional feature: define COUNTER_COMPARE_EN to build the compare-match pulse
// on match_o; without it match_o is tied low and compare_i is ignored.
module prescaled_counter #(
  parameter int WIDTH          = 8,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                  clock_i,
  input  logic                  reset_ni,
  prescaled_counter_if.slave    bus
);

  localparam logic [WIDTH-1:0]          CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]          CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PRESCALE_WIDTH-1:0] PS_ONE  = {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]          count_q,    count_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic                      tick_q,     tick_d;
  logic                      wrap_q,     wrap_d;
  logic [PRESCALE_WIDTH-1:0] div_eff;
  logic                      terminal;
  logic [WIDTH:0]            step_res;

  // One count step at the limits: returns {wrap, next_count}. Saturating mode
  // holds at the limit; wrapping mode rolls over and flags the wrap.
  function automatic logic [WIDTH:0] step_count(
    input logic [WIDTH-1:0] cnt,
    input logic             up,
    input logic             sat
  );
    logic [WIDTH:0] res;
    if (up) begin
      if (cnt == CNT_MAX) res = sat ? {1'b0, cnt} : {1'b1, {WIDTH{1'b0}}};
      else                res = {1'b0, cnt + CNT_ONE};
    end else begin
      if (cnt == '0)      res = sat ? {1'b0, cnt} : {1'b1, CNT_MAX};
      else                res = {1'b0, cnt - CNT_ONE};
    end
    return res;
  endfunction

  // Divide of 0 behaves as 1. Using >= lets a lowered divide terminate at
  // once instead of running the prescaler past its new limit.
  assign div_eff  = (bus.divide_i == '0) ? PS_ONE : bus.divide_i;
  assign terminal = (prescale_q >= (div_eff - PS_ONE));
  assign step_res = step_count(count_q, bus.up_i, bus.saturate_i);

  // Next-state decision with priority clear > load > enable.
  always_comb begin
    count_d    = count_q;
    prescale_d = prescale_q;
    tick_d     = 1'b0;
    wrap_d     = 1'b0;
    if (bus.clear_i) begin
      count_d    = '0;
      prescale_d = '0;
    end else if (bus.load_i) begin
      count_d    = bus.load_value_i;
      prescale_d = '0;
    end else if (bus.enable_i) begin
      if (terminal) begin
        prescale_d = '0;
        tick_d     = 1'b1;
        count_d    = step_res[WIDTH-1:0];
        wrap_d     = step_res[WIDTH];
      end else begin
        prescale_d = prescale_q + PS_ONE;
      end
    end
  end

  // Count, prescaler and pulse registers.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      count_q    <= '0;
      prescale_q <= '0;
      tick_q     <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      count_q    <= count_d;
      prescale_q <= prescale_d;
      tick_q     <= tick_d;
      wrap_q     <= wrap_d;
    end
  end

`ifdef COUNTER_COMPARE_EN
  logic match_q, match_d;

  // Match fires on any step (including a saturated hold) that lands on compare_i.
  always_comb begin
    match_d = tick_d && (count_d == bus.compare_i);
  end

  // Compare-match pulse register.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) match_q <= 1'b0;
    else           match_q <= match_d;
  end

  assign bus.match_o = match_q;
`else
  logic unused_compare;
  assign unused_compare = ^bus.compare_i;
  assign bus.match_o    = 1'b0;
`endif

  assign bus.count_o    = count_q;
  assign bus.prescale_o = prescale_q;
  assign bus.tick_o     = tick_q;
  assign bus.wrap_o     = wrap_q;
  assign bus.full_o     = (count_q == CNT_MAX);
  assign bus.zero_o     = (count_q == '0);

endmodule
